// File: rtl/relu_maxpool_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | relu_maxpool_pkg : shared window-phase, pool-entry and default types  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package relu_maxpool_pkg;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RELU_EN_DEF    = 1;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] idx;
    logic       last;
  } pool_entry_t;

endpackage : relu_maxpool_pkg
`default_nettype wire

// File: rtl/relu_maxpool_pool_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pool_fifo : synchronous FIFO of pool entries with registered head     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module pool_fifo
  import relu_maxpool_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  pool_entry_t data_i,
  input  logic        pop_i,
  output logic        valid_o,
  output pool_entry_t data_o,
  output logic        full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pool_entry_t         mem_q [DEPTH];
  pool_entry_t         mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                valid_q, valid_d;
  pool_entry_t         head_q, head_d;
  logic                do_push, do_pop;
  logic [CW-1:0]       remain;

  always_comb begin
    full_o   = (count_q == CW'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    remain  = count_q - CW'(do_pop);
    valid_d = (count_d != '0);
    // The head register is loaded with whatever will sit at rd_ptr_d after this
    // edge; if the queue drains to nothing, that is the entry being written now.
    if (count_d == '0) begin
      head_d = '0;
    end else if (remain == '0) begin
      head_d = data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = head_q;

endmodule : pool_fifo
`default_nettype wire

// File: rtl/relu_maxpool.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | relu_maxpool : ReLU + 2x2 max-pool over a conv sample stream          |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RELU_EN    = RELU_EN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       conv_valid_i,
  input  logic       last_i,
  input  logic [7:0] conv_result_i,
  input  logic [9:0] addr_i,
  input  logic       clr_i,
  output logic       pool_valid_o,
  input  logic       pool_ready_i,
  output logic [7:0] pool_data_o,
  output logic [7:0] pool_idx_o,
  output logic       pool_last_o,
  output logic       overflow_o,
  output logic       frag_o,
  output logic [9:0] dbg_addr_o
);

  phase_e            phase_q, phase_d;
  logic signed [7:0] max_q, max_d;
  logic [7:0]        win_idx_q, win_idx_d;
  logic              overflow_q, overflow_d;
  logic              frag_q, frag_d;
  logic [9:0]        dbg_addr_q, dbg_addr_d;

  logic signed [7:0] sample;
  logic signed [7:0] cand;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_valid;
  logic              frag_ev;
  logic              ovf_ev;
  pool_entry_t       push_entry;
  pool_entry_t       head;

  always_comb begin
    sample = $signed(conv_result_i);
    if ((RELU_EN != 0) && (sample < 0)) begin
      sample = '0;
    end
    cand = ((phase_q == PH0) || (sample > max_q)) ? sample : max_q;

    push            = conv_valid_i && ((phase_q == PH3) || last_i);
    push_entry.data = cand;
    push_entry.idx  = win_idx_q;
    push_entry.last = last_i;
    pop             = fifo_valid && pool_ready_i;

    phase_d    = phase_q;
    max_d      = max_q;
    win_idx_d  = win_idx_q;
    dbg_addr_d = dbg_addr_q;

    if (conv_valid_i) begin
      if (phase_q == PH0) begin
        dbg_addr_d = addr_i;
      end
      if (push) begin
        phase_d   = PH0;
        max_d     = '0;
        win_idx_d = last_i ? 8'd0 : win_idx_q + 8'd1;
      end else begin
        max_d = cand;
        case (phase_q)
          PH0:     phase_d = PH1;
          PH1:     phase_d = PH2;
          PH2:     phase_d = PH3;
          default: phase_d = PH0;
        endcase
      end
    end

    // Error events take priority over a simultaneous clear.
    frag_ev    = push && last_i && (phase_q != PH3);
    ovf_ev     = push && fifo_full && !pop;
    frag_d     = frag_ev || (frag_q && !clr_i);
    overflow_d = ovf_ev || (overflow_q && !clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH0;
      max_q      <= '0;
      win_idx_q  <= '0;
      overflow_q <= 1'b0;
      frag_q     <= 1'b0;
      dbg_addr_q <= '0;
    end else begin
      phase_q    <= phase_d;
      max_q      <= max_d;
      win_idx_q  <= win_idx_d;
      overflow_q <= overflow_d;
      frag_q     <= frag_d;
      dbg_addr_q <= dbg_addr_d;
    end
  end

  pool_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pool_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (head),
    .full_o  (fifo_full)
  );

  assign pool_valid_o = fifo_valid;
  assign pool_data_o  = head.data;
  assign pool_idx_o   = head.idx;
  assign pool_last_o  = head.last;
  assign overflow_o   = overflow_q;
  assign frag_o       = frag_q;
  assign dbg_addr_o   = dbg_addr_q;

endmodule : relu_maxpool
`default_nettype wire

// File: tb/tb_relu_maxpool.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_relu_maxpool : scoreboard bench, ReLU-on and ReLU-off instances    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_relu_maxpool;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       conv_valid_i = 1'b0;
  logic       last_i = 1'b0;
  logic [7:0] conv_result_i = '0;
  logic [9:0] addr_i = '0;
  logic       clr_i = 1'b0;
  logic       pool_ready_i = 1'b0;

  logic       p1_valid, p1_last, p1_ovf, p1_frag;
  logic [7:0] p1_data, p1_idx;
  logic [9:0] p1_dbg;
  logic       p0_valid, p0_last, p0_ovf, p0_frag;
  logic [7:0] p0_data, p0_idx;
  logic [9:0] p0_dbg;

  int checks   = 0;
  int failures = 0;

  // Expected entries {data, idx, last} per instance.
  logic [16:0] sb1[$];
  logic [16:0] sb0[$];

  int         win_s[$];
  logic [7:0] idx_m = '0;
  logic       ov_exp = 1'b0;
  logic       fr_exp = 1'b0;
  logic [9:0] dbg_exp = '0;
  logic [9:0] addr_cnt = '0;

  always #5 clk = ~clk;

  relu_maxpool #(.FIFO_DEPTH(DEPTH), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .conv_valid_i(conv_valid_i), .last_i(last_i),
    .conv_result_i(conv_result_i), .addr_i(addr_i), .clr_i(clr_i),
    .pool_valid_o(p1_valid), .pool_ready_i(pool_ready_i), .pool_data_o(p1_data),
    .pool_idx_o(p1_idx), .pool_last_o(p1_last), .overflow_o(p1_ovf),
    .frag_o(p1_frag), .dbg_addr_o(p1_dbg)
  );

  relu_maxpool #(.FIFO_DEPTH(DEPTH), .RELU_EN(0)) dut_raw (
    .clk(clk), .rst(rst), .conv_valid_i(conv_valid_i), .last_i(last_i),
    .conv_result_i(conv_result_i), .addr_i(addr_i), .clr_i(clr_i),
    .pool_valid_o(p0_valid), .pool_ready_i(pool_ready_i), .pool_data_o(p0_data),
    .pool_idx_o(p0_idx), .pool_last_o(p0_last), .overflow_o(p0_ovf),
    .frag_o(p0_frag), .dbg_addr_o(p0_dbg)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge valid&&ready
  // means the head is popped on the coming edge.
  always @(negedge clk) begin
    if (!rst && pool_ready_i) begin
      if (p1_valid) begin
        checks++;
        if (sb1.size() == 0) begin
          failures++;
          $display("FAIL head_relu actual=%0h expected=none", {p1_data, p1_idx, p1_last});
        end else begin
          logic [16:0] e;
          e = sb1.pop_front();
          checks--;
          chk("head_relu", {15'd0, p1_data, p1_idx, p1_last}, {15'd0, e});
        end
      end
      if (p0_valid) begin
        checks++;
        if (sb0.size() == 0) begin
          failures++;
          $display("FAIL head_raw actual=%0h expected=none", {p0_data, p0_idx, p0_last});
        end else begin
          logic [16:0] e;
          e = sb0.pop_front();
          checks--;
          chk("head_raw", {15'd0, p0_data, p0_idx, p0_last}, {15'd0, e});
        end
      end
    end
  end

  // One clock of stimulus; the reference model works on whole windows.
  task automatic cycle(input bit v, input bit l, input int d, input bit rdy, input bit c);
    bit ov_ev = 0;
    bit fr_ev = 0;
    addr_cnt      = addr_cnt + 10'd1;
    conv_valid_i  = v;
    last_i        = l;
    conv_result_i = 8'(d);
    addr_i        = addr_cnt;
    pool_ready_i  = rdy;
    clr_i         = c;
    if (v) begin
      if (win_s.size() == 0) dbg_exp = addr_cnt;
      win_s.push_back(d);
      if (win_s.size() == 4 || l) begin
        int m1 = -1000;
        int m0 = -1000;
        bit pop_m;
        foreach (win_s[k]) begin
          int r = (win_s[k] < 0) ? 0 : win_s[k];
          if (r > m1) m1 = r;
          if (win_s[k] > m0) m0 = win_s[k];
        end
        fr_ev = (win_s.size() < 4);
        pop_m = (sb1.size() > 0) && rdy;
        if (sb1.size() < DEPTH || pop_m) begin
          sb1.push_back({8'(m1), idx_m, l});
          sb0.push_back({8'(m0), idx_m, l});
        end else begin
          ov_ev = 1;
        end
        idx_m = l ? 8'd0 : idx_m + 8'd1;
        win_s.delete();
      end
    end
    ov_exp = ov_ev | (ov_exp & ~c);
    fr_exp = fr_ev | (fr_exp & ~c);
    @(posedge clk);
    #1;
    chk("valid_relu", {31'd0, p1_valid}, {31'd0, sb1.size() != 0});
    chk("valid_raw", {31'd0, p0_valid}, {31'd0, sb0.size() != 0});
    chk("overflow", {30'd0, p1_ovf, p0_ovf}, {30'd0, ov_exp, ov_exp});
    chk("frag", {30'd0, p1_frag, p0_frag}, {30'd0, fr_exp, fr_exp});
    chk("dbg_addr", {22'd0, p1_dbg}, {22'd0, dbg_exp});
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, {p1_valid, p1_data, p1_idx, p1_last, p1_ovf, p1_frag, p1_dbg}, 32'd0);
    chk(nm, {p0_valid, p0_data, p0_idx, p0_last, p0_ovf, p0_frag, p0_dbg}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; conv_valid_i = 1'b0; last_i = 1'b0; pool_ready_i = 1'b0; clr_i = 1'b0;
    sb1.delete(); sb0.delete(); win_s.delete();
    idx_m = '0; ov_exp = 1'b0; fr_exp = 1'b0; dbg_exp = '0;
    @(posedge clk);
    #1;
    check_all_zero("in_reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("after_reset");
  endtask

  initial begin
    int dir_a[4];
    do_reset();

    // ReLU then max: -5,12,7,-128 -> 12 on the cycle after the 4th sample
    dir_a = '{-5, 12, 7, -128};
    foreach (dir_a[k]) cycle(1, 0, dir_a[k], (k == 3) ? 1'b0 : 1'b1, 0);
    chk("dir_first_data", {p1_valid, p1_data, p1_idx, p1_last}, {1'b1, 8'd12, 8'd0, 1'b0});
    cycle(0, 0, 0, 1, 0);

    // All-negative window
    dir_a = '{-5, -3, -9, -1};
    foreach (dir_a[k]) cycle(1, 0, dir_a[k], 0, 0);
    chk("dir_neg_relu", {24'd0, p1_data}, 32'd0);
    chk("dir_neg_raw", {24'd0, p0_data}, 32'h0000_00ff);
    repeat (2) cycle(0, 0, 0, 1, 0);

    // Channel of 4 windows, then next channel restarts at idx 0
    do_reset();
    for (int k = 0; k < 20; k++) cycle(1, k == 15, (k * 7) % 50 - 10, 1, 0);
    chk("dir_restart_idx", {24'd0, p1_idx}, 32'd0);
    repeat (2) cycle(0, 0, 0, 1, 0);

    // Overflow with ready low, then drain
    for (int k = 0; k < 20; k++) cycle(1, 0, k, 0, 0);
    chk("dir_overflow", {31'd0, p1_ovf}, 32'd1);
    repeat (6) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);

    // Fragment: last on 2nd sample
    cycle(1, 0, 3, 1, 0);
    cycle(1, 1, 9, 1, 0);
    chk("dir_frag_set", {31'd0, p1_frag}, 32'd1);
    chk("dir_frag_data", {p1_data, p1_last}, {8'd9, 1'b1});
    cycle(0, 0, 0, 1, 1);
    chk("dir_frag_clr", {31'd0, p1_frag}, 32'd0);

    // Reset mid-window with entries queued
    for (int k = 0; k < 10; k++) cycle(1, 0, 20 + k, 0, 0);
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1, 0, 40 - k, 1, 0);
    chk("dir_post_reset", {p1_valid, p1_data, p1_idx}, {1'b1, 8'd40, 8'd0});
    cycle(0, 0, 0, 1, 0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 255)) - 128, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
    end

    repeat (DEPTH + 4) cycle(0, 0, 0, 1, 0);
    chk("drain_relu", sb1.size(), 0);
    chk("drain_raw", sb0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_relu_maxpool
`default_nettype wire

// File: doc/relu_maxpool.md
RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, minimum 2.
REQ-002 Parameter RELU_EN, default 1: 1 clamps negative samples to 0 before pooling; 0 pools raw signed values.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 conv_valid_i  input  1  sample qualifier from the accumulator; there is no ready signal, so every valid cycle is consumed.
REQ-006 last_i  input  1  marks the final sample of the current ofmap channel; meaningful only when conv_valid_i=1.
REQ-007 conv_result_i  input  8  signed two's-complement saturated conv sample.
REQ-008 addr_i  input  10  accumulator read address of the sample; captured only for debug.
REQ-009 clr_i  input  1  clears the sticky error flags.
REQ-010 pool_valid_o  output  1  FIFO head is valid.
REQ-011 pool_ready_i  input  1  downstream accepts the head.
REQ-012 pool_data_o  output  8  pooled result, signed.
REQ-013 pool_idx_o  output  8  window index within the channel, starting at 0.
REQ-014 pool_last_o  output  1  head is the final window of the channel.
REQ-015 overflow_o  output  1  sticky flag: a window was dropped because the FIFO was full.
REQ-016 frag_o  output  1  sticky flag: last_i arrived before a 4-sample window completed.
REQ-017 dbg_addr_o  output  10  addr_i of the first sample of the most recently started window.

Function
REQ-018 Samples are grouped in arrival order into 2x2 windows of 4 consecutive valid samples; a 2-bit phase counter tracks the position (0..3).
REQ-019 Each sample is first passed through ReLU when RELU_EN=1: a negative value becomes 8'sd0.
REQ-020 Phase 0 loads the running max with the processed sample; phases 1-3 keep the signed maximum of the running max and the sample.
REQ-021 When the phase-3 sample arrives, the entry {max including this sample, win_idx, last_i} is pushed into the FIFO in the same cycle; the phase counter then wraps to 0.
REQ-022 Latency: pool_valid_o rises on the first cycle after the phase-3 sample (1 cycle) if the FIFO was empty.
REQ-023 win_idx increments after each push and returns to 0 after a push whose last flag is 1.
REQ-024 When last_i=1 at phase 0-2: push the partial window max with last=1, set frag_o, and reset phase and win_idx to 0.
REQ-025 FIFO handshake: an entry pops when pool_valid_o and pool_ready_i are both 1; pool_data_o, pool_idx_o and pool_last_o hold stable while pool_valid_o=1 and pool_ready_i=0.
REQ-026 Push while full without a pop in the same cycle: the entry is dropped, overflow_o is set, and the window counters still advance.
REQ-027 Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
REQ-028 Push and pop in the same cycle while empty: the new entry appears on the next cycle; no bypass path.
REQ-029 FIFO read and write pointers wrap modulo FIFO_DEPTH; full and empty are derived from an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-030 clr_i clears overflow_o and frag_o on the next edge; if an error event occurs in the same cycle, the flag is set (set wins).

Reset
REQ-031 rst=1 clears the phase, running max, win_idx, FIFO pointers and count, overflow_o, frag_o and dbg_addr_o to 0.
REQ-032 All outputs are 0 during reset and on the first cycle after it.
REQ-033 rst asserted mid-window or with the FIFO non-empty discards all partial and queued data; no entry is emitted after reset.

Structure
REQ-034 A shared package holds the window-phase constants (PH0..PH3), the pool entry struct {data[7:0], idx[7:0], last}, and the RELU_EN and FIFO_DEPTH defaults.
REQ-035 A single sub-module, pool_fifo (synchronous, parameterised, registered outputs), holds the queue; the window logic lives in relu_maxpool.

Verification
REQ-036 Directed: samples -5, 12, 7, -128 with RELU_EN=1 and ready held high -> one entry {12, idx 0, last 0} with pool_valid_o high on the cycle after the 4th sample.
REQ-037 Directed: samples -5, -3, -9, -1 -> data 0 with RELU_EN=1; data -1 with RELU_EN=0.
REQ-038 Directed: 16 samples (4 windows), last_i on the 16th, ready high -> indices 0,1,2,3, pool_last_o only on idx 3, and the next channel restarts at idx 0.
REQ-039 Directed: FIFO_DEPTH=4, ready low, 5 windows -> 4 entries queued, overflow_o=1; raise ready -> exactly windows 0-3 drain in order.
REQ-040 Directed: last_i on the 2nd sample of a window (samples 3, 9) -> entry {9, last 1} and frag_o=1; clr_i -> frag_o=0 on the next cycle.
REQ-041 Directed: rst pulse after 2 samples with 2 entries queued -> pool_valid_o=0 on the next cycle, and the next 4 samples produce idx 0 with no stale data.
